// File: rtl/irq_timer.sv
// irq_timer: 16-bit down-counting interval timer with an 8-bit prescaler,
// optional auto-reload and a sticky expiry flag that raises irq.
//
// Bus protocol: the CPU presents select/write/address/datain for one clock.
// A write (select & write) updates the addressed register at that edge.
// A read (select & !write) returns the addressed register on dataout one
// clock later. dataout is 0 whenever no read was captured, so it can be
// wired-ORed onto a shared bus.
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [15:0] datain,
  output logic [15:0] dataout,
  output logic        irq
);

  localparam logic [1:0] ADDR_COUNT  = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [15:0] count;
  logic [15:0] reload;
  logic        en;
  logic        ie;
  logic        ar;
  logic [7:0]  prescale;
  logic [7:0]  pc;
  logic        exp_flag;

  logic        wr_count;
  logic        wr_reload;
  logic        wr_ctrl;
  logic        wr_status;
  logic        rd;
  logic        tick;
  logic        tick_eff;
  logic        expiry;
  logic [15:0] rd_mux;

  // Bus decode and timer event qualification.
  always_comb begin
    wr_count  = select & write & (address == ADDR_COUNT);
    wr_reload = select & write & (address == ADDR_RELOAD);
    wr_ctrl   = select & write & (address == ADDR_CTRL);
    wr_status = select & write & (address == ADDR_STATUS);
    rd        = select & ~write;
    tick      = en & (pc == prescale);
    // A COUNT write overrides the tick entirely; a CTRL write that turns
    // EN off cancels the tick it coincides with.
    tick_eff  = tick & ~wr_count & ~(wr_ctrl & ~datain[0]);
    expiry    = tick_eff & (count == 16'd0);
  end

  // Read data mux over the pre-edge register values.
  always_comb begin
    rd_mux = 16'd0;
    case (address)
      ADDR_COUNT:  rd_mux = count;
      ADDR_RELOAD: rd_mux = reload;
      ADDR_CTRL:   rd_mux = {prescale, 5'd0, ar, ie, en};
      ADDR_STATUS: rd_mux = {15'd0, exp_flag};
      default:     rd_mux = 16'd0;
    endcase
  end

  // Prescaler: free-runs while enabled, restarts on any CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 8'd0;
    end else if (wr_ctrl || !en || tick) begin
      pc <= 8'd0;
    end else begin
      pc <= pc + 8'd1;
    end
  end

  // COUNT: bus write wins, otherwise decrement or reload on a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (wr_count) begin
      count <= datain;
    end else if (tick_eff) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (ar) begin
        count <= reload;
      end
    end
  end

  // RELOAD register; an expiry on the same edge uses the old value above.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= 16'd0;
    end else if (wr_reload) begin
      reload <= datain;
    end
  end

  // CTRL fields; one-shot expiry clears EN unless software writes EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      ar       <= 1'b0;
      prescale <= 8'd0;
    end else if (wr_ctrl) begin
      en       <= datain[0];
      ie       <= datain[1];
      ar       <= datain[2];
      prescale <= datain[15:8];
    end else if (expiry && !ar) begin
      en <= 1'b0;
    end
  end

  // Sticky expiry flag; setting beats a coincident write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_flag <= 1'b0;
    end else if (expiry) begin
      exp_flag <= 1'b1;
    end else if (wr_status && datain[0]) begin
      exp_flag <= 1'b0;
    end
  end

  // Registered read data, zero when no read is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout <= 16'd0;
    end else if (rd) begin
      dataout <= rd_mux;
    end else begin
      dataout <= 16'd0;
    end
  end

  // Built from flops only, so there is no path from the bus inputs.
  assign irq = exp_flag & ie;

endmodule
